// File: rtl/mhd_pair_gen_if.sv
// Stream/control bundle for mhd_pair_gen.
// master: the generator (drives busy, beat fields, done).
// slave : the consumer/driver side (drives start, a_in, out_ready).
interface mhd_pair_gen_if #(
  parameter int WIDTH = 9
);
  localparam int WW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WW-1:0]    weight_out;
  logic             out_last;
  logic             done;

  modport master (
    input  start, a_in, out_ready,
    output busy, out_valid, a_out, b_out, weight_out, out_last, done
  );

  modport slave (
    output start, a_in, out_ready,
    input  busy, out_valid, a_out, b_out, weight_out, out_last, done
  );
endinterface

// File: rtl/mhd_pair_gen.sv
// mhd_pair_gen: enumerates every b with popcount(a ^ b) <= MHD as a
// valid/ready stream, in ascending order of the error pattern a ^ b.
// One candidate pattern is examined per step; non-qualifying candidates
// leave a bubble on the stream.
// Build option: MHD_GEN_EXACT_EN -- emit only patterns of weight == MHD.
module mhd_pair_gen #(
  parameter int WIDTH = 9,
  parameter int MHD   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mhd_pair_gen_if.master bus
);
  localparam int WW = $clog2(WIDTH + 1);
  // Highest qualifying pattern: the top min(MHD,WIDTH) bits set.
  localparam int               M        = (MHD < WIDTH) ? MHD : WIDTH;
  localparam logic [WIDTH-1:0] ONES     = '1;
  localparam logic [WIDTH-1:0] LASTPAT  = ONES << (WIDTH - M);
  // Candidate counter is one bit wider so the final pattern is unambiguous.
  localparam logic [WIDTH:0]   CAND_END = {1'b0, ONES};

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t         state, state_nxt;
  logic [WIDTH:0] cand;
  logic [WW-1:0]  cand_pc;
  logic           qual;
  logic           step;
  logic           scan_end;

  function automatic logic [WW-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [WW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + WW'(v[i]);
    return c;
  endfunction

  // Candidate weight, qualification and step/end-of-scan strobes.
  always_comb begin
    cand_pc  = popcnt(cand[WIDTH-1:0]);
`ifdef MHD_GEN_EXACT_EN
    qual     = (int'(cand_pc) == MHD);
`else
    qual     = (int'(cand_pc) <= MHD);
`endif
    step     = (state == SCAN) && (!bus.out_valid || bus.out_ready);
    scan_end = (cand == CAND_END);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = SCAN;
      SCAN:  if (step && scan_end) state_nxt = qual ? DRAIN : DONE;
      DRAIN: if (bus.out_ready) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs decoded from state.
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // Reference capture, candidate counter and the output beat register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.a_out      <= '0;
      bus.b_out      <= '0;
      bus.weight_out <= '0;
      bus.out_last   <= 1'b0;
      bus.out_valid  <= 1'b0;
      cand           <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        bus.a_out <= bus.a_in;
        cand      <= '0;
      end
    end else if (step) begin
      cand <= cand + 1'b1;
      if (qual) begin
        bus.out_valid  <= 1'b1;
        bus.b_out      <= bus.a_out ^ cand[WIDTH-1:0];
        bus.weight_out <= cand_pc;
        bus.out_last   <= (cand[WIDTH-1:0] == LASTPAT);
      end else begin
        // Bubble: b_out/weight_out keep stale data, out_last only rides
        // with a valid beat.
        bus.out_valid  <= 1'b0;
        bus.out_last   <= 1'b0;
      end
    end else if (state == DRAIN && bus.out_ready) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end
  end

  // A stalled beat must not change under the consumer.
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.b_out)
      && $stable(bus.weight_out) && $stable(bus.out_last));

  // out_last never appears without a beat.
  a_last_valid: assert property (@(posedge clk) disable iff (!rst_n)
    bus.out_last |-> bus.out_valid);

  // The stream is empty by the time done pulses.
  a_done_empty: assert property (@(posedge clk) disable iff (!rst_n)
    bus.done |-> !bus.out_valid);
endmodule

// File: tb/tb_mhd_pair_gen.sv
// Scoreboard bench for mhd_pair_gen: stimulus pushes expected beats,
// per-DUT monitors pop and compare on every accepted beat.
module tb_mhd_pair_gen;
  localparam int MH = 4;
`ifdef MHD_GEN_EXACT_EN
  localparam int EXP_N  = 126;
  localparam int EXP_NB = 0;
`else
  localparam int EXP_N  = 256;
  localparam int EXP_NB = 16;
`endif

  typedef struct packed {
    logic [8:0] b;
    logic [3:0] w;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   rnd = 1'b0;
  always #5 clk = ~clk;

  mhd_pair_gen_if #(.WIDTH(9)) m ();
  mhd_pair_gen_if #(.WIDTH(4)) s0 ();
  mhd_pair_gen_if #(.WIDTH(4)) s1 ();

  mhd_pair_gen #(.WIDTH(9), .MHD(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(m.master));
  mhd_pair_gen #(.WIDTH(4), .MHD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(s0.master));
  mhd_pair_gen #(.WIDTH(4), .MHD(5)) dut1 (.clk(clk), .rst_n(rst_n), .bus(s1.master));

  beat_t q0[$], qa[$], qb[$];
  int checks = 0, fails = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit qual(input int pc, input int mhd);
`ifdef MHD_GEN_EXACT_EN
    return pc == mhd;
`else
    return pc <= mhd;
`endif
  endfunction

  // Expected stream: all patterns of the given width in ascending order.
  task automatic push_exp(input int w, input int mhd, input logic [8:0] a,
                          input logic [8:0] lastpat, input int sel);
    for (int p = 0; p < (1 << w); p++) begin
      int pc;
      beat_t e;
      pc = $countones(p);
      e.b = a ^ 9'(p);
      e.w = 4'(pc);
      e.last = (9'(p) == lastpat);
      if (qual(pc, mhd)) begin
        case (sel)
          0: q0.push_back(e);
          1: qa.push_back(e);
          default: qb.push_back(e);
        endcase
      end
    end
  endtask

  // Main-DUT monitor state.
  int beats0 = 0, lasts0 = 0, dones0 = 0;
  logic [8:0] lastb0 = '0, exp_a0 = '0;
  logic [3:0] lastw0 = '0;
  bit pst = 1'b0;
  beat_t pv;

  always @(negedge clk) begin
    beat_t got, e;
    got = {m.b_out, m.weight_out, m.out_last};
    if (!rst_n) pst = 1'b0;
    else begin
      if (pst) chk(m.out_valid && got == pv, "stall_hold", got, pv);
      if (m.out_valid && m.out_ready) begin
        chk(q0.size() != 0, "beat_expected", q0.size(), 1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk(got == e, "beat", got, e);
        end
        chk(m.a_out == exp_a0, "a_out", m.a_out, exp_a0);
        chk($countones(m.a_out ^ m.b_out) == int'(m.weight_out) && int'(m.weight_out) <= MH,
            "miter_weight", m.weight_out, $countones(m.a_out ^ m.b_out));
        beats0++;
        lastb0 = m.b_out;
        lastw0 = m.weight_out;
        if (m.out_last) lasts0++;
      end
      pst = m.out_valid && !m.out_ready;
      pv  = got;
      if (m.done) begin
        chk(q0.size() == 0, "drained_at_done", q0.size(), 0);
        dones0++;
      end
    end
  end

  // Small-DUT monitors.
  int beatsA = 0, lastsA = 0, donesA = 0, beatsB = 0, lastsB = 0, donesB = 0;

  always @(negedge clk) begin
    beat_t got, e;
    got = {5'b0, s0.b_out, 1'b0, s0.weight_out, s0.out_last};
    if (rst_n && s0.out_valid && s0.out_ready) begin
      chk(qa.size() != 0, "s0_beat_expected", qa.size(), 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk(got == e, "s0_beat", got, e);
      end
      beatsA++;
      if (s0.out_last) lastsA++;
    end
    if (rst_n && s0.done) donesA++;
  end

  always @(negedge clk) begin
    beat_t got, e;
    got = {5'b0, s1.b_out, 1'b0, s1.weight_out, s1.out_last};
    if (rst_n && s1.out_valid && s1.out_ready) begin
      chk(qb.size() != 0, "s1_beat_expected", qb.size(), 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk(got == e, "s1_beat", got, e);
      end
      beatsB++;
      if (s1.out_last) lastsB++;
    end
    if (rst_n && s1.done) donesB++;
  end

  // Consumer ready: always 1, or stalled ~30% of cycles.
  always @(posedge clk) begin
    #1;
    m.out_ready = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  task automatic start_main(input logic [8:0] a);
    @(posedge clk) #1;
    m.start = 1'b1;
    m.a_in  = a;
    exp_a0  = a;
    push_exp(9, 4, a, 9'h1E0, 0);
    @(posedge clk) #1;
    m.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!m.done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(m.done, nm, n, 0);
  endtask

  initial begin
    int bb, lb, db;
    m.start = 0;  m.a_in = '0;
    s0.start = 0; s0.a_in = '0; s0.out_ready = 1'b1;
    s1.start = 0; s1.a_in = '0; s1.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({m.busy, m.out_valid, m.done, m.out_last} == 4'b0, "reset_ctrl",
        {m.busy, m.out_valid, m.done, m.out_last}, 0);
    chk({m.a_out, m.b_out, m.weight_out} == '0, "reset_data",
        {m.a_out, m.b_out, m.weight_out}, 0);
    chk({s0.busy, s0.out_valid, s1.busy, s1.out_valid} == 4'b0, "reset_small",
        {s0.busy, s0.out_valid, s1.busy, s1.out_valid}, 0);
    rst_n = 1'b1;

    // Run 1: a=0x0AB, out_ready=1
    bb = beats0; lb = lasts0; db = dones0;
    start_main(9'h0AB);
    m.a_in = 9'h155;
    @(negedge clk);
    chk(m.busy == 1'b1, "busy_after_start", m.busy, 1);
    chk(m.out_valid == 1'b0, "latency_early", m.out_valid, 0);
    @(negedge clk);
    chk(m.out_valid == qual(0, MH), "latency_first", m.out_valid, qual(0, MH));
`ifndef MHD_GEN_EXACT_EN
    chk(m.b_out == 9'h0AB && m.weight_out == 4'd0, "first_beat", m.b_out, 9'h0AB);
`endif
    // start while busy must be ignored
    @(posedge clk) #1;
    m.start = 1'b1;
    m.a_in  = 9'h155;
    @(posedge clk) #1;
    m.start = 1'b0;
    @(negedge clk);
    chk(m.a_out == 9'h0AB, "start_while_busy", m.a_out, 9'h0AB);
    wait_done("run1_done");
    chk(m.busy == 1'b1, "busy_in_done", m.busy, 1);
    chk(beats0 - bb == EXP_N, "run1_count", beats0 - bb, EXP_N);
    chk(lastb0 == 9'h14B && lastw0 == 4'd4, "run1_last_beat", lastb0, 9'h14B);
    chk(lasts0 - lb == 1, "run1_last_once", lasts0 - lb, 1);
    // start during DONE must be ignored
    m.start = 1'b1;
    m.a_in  = 9'h0F0;
    @(posedge clk) #1;
    m.start = 1'b0;
    @(negedge clk);
    chk(m.busy == 1'b0, "start_in_done_ignored", m.busy, 0);
    chk(m.done == 1'b0, "done_one_cycle", m.done, 0);
    chk(dones0 - db == 1, "run1_done_once", dones0 - db, 1);

    // Run 2: back-to-back from IDLE with backpressure
    rnd = 1'b1;
    bb = beats0; lb = lasts0;
    start_main(9'h155);
    @(negedge clk);
    chk(m.busy == 1'b1, "run2_accepted", m.busy, 1);
    wait_done("run2_done");
    rnd = 1'b0;
    chk(beats0 - bb == EXP_N, "run2_count", beats0 - bb, EXP_N);
    chk(lastb0 == (9'h155 ^ 9'h1E0), "run2_last_beat", lastb0, 9'h155 ^ 9'h1E0);
    chk(lasts0 - lb == 1, "run2_last_once", lasts0 - lb, 1);
    repeat (2) @(negedge clk);

    // Run 3: reset after 100 beats
    bb = beats0;
    start_main(9'h0F0);
    for (int i = 0; i < 2000 && beats0 - bb < 100; i++) @(posedge clk);
    chk(beats0 - bb >= 100, "reach_100_beats", beats0 - bb, 100);
    db = dones0;
    #3 rst_n = 1'b0;
    #1;
    chk({m.busy, m.out_valid, m.done, m.out_last, m.a_out, m.b_out, m.weight_out} == '0,
        "async_reset", {m.busy, m.out_valid, m.a_out, m.b_out}, 0);
    q0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk(dones0 == db, "no_done_after_reset", dones0 - db, 0);

    // Run 4: fresh run after reset restarts from pattern 0
    bb = beats0;
    start_main(9'h003);
    wait_done("run4_done");
    chk(beats0 - bb == EXP_N, "run4_count", beats0 - bb, EXP_N);
    repeat (2) @(negedge clk);

    // Small configurations: WIDTH=4 with MHD=0 and MHD=5
    @(posedge clk) #1;
    s0.start = 1'b1; s0.a_in = 4'h5;
    s1.start = 1'b1; s1.a_in = 4'hA;
    push_exp(4, 0, 9'h005, 9'h000, 1);
    push_exp(4, 5, 9'h00A, 9'h00F, 2);
    @(posedge clk) #1;
    s0.start = 1'b0;
    s1.start = 1'b0;
    repeat (40) @(negedge clk);
    chk(beatsA == 1, "w4m0_count", beatsA, 1);
    chk(lastsA == 1, "w4m0_last", lastsA, 1);
    chk(donesA == 1, "w4m0_done", donesA, 1);
    chk(qa.size() == 0, "w4m0_drained", qa.size(), 0);
    chk(beatsB == EXP_NB, "w4m5_count", beatsB, EXP_NB);
    chk(lastsB == (EXP_NB != 0 ? 1 : 0), "w4m5_last", lastsB, EXP_NB != 0);
    chk(donesB == 1, "w4m5_done", donesB, 1);
    chk(qb.size() == 0, "w4m5_drained", qb.size(), 0);
    chk(s0.busy == 1'b0 && s1.busy == 1'b0, "small_idle", {s0.busy, s1.busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
